servo_motion_ctrl: RTL

SERVO_MOTION_CTRL -- requirements
Module: servo_motion_ctrl

---
 rtl/servo_motion_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/servo_motion_ctrl.sv
// Four-joint servo motion controller: each frame every joint moves at most
// STEP_DEG degrees towards its commanded target, one joint per cycle.
module servo_motion_ctrl #(
    parameter int FRAME_CYCLES = 1_000_000,
    parameter int STEP_DEG     = 2,
    parameter int HOME_DEG     = 90
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_joint,
    input  logic [7:0]  cmd_angle,
    input  logic        estop,
    output logic [31:0] angle_out,
    output logic        busy,
    output logic        done
);
    localparam int CW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;

    typedef enum logic {IDLE, UPDATE} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt;
    logic            frame_tick;
    logic [1:0]      j, j_nx;
    logic [3:0][7:0] cur, tgt, cur_nx, tgt_nx;
    logic            chg_frame, chg_nx, done_nx;
    logic signed [8:0] d, ad;
    logic [7:0]      stepped;

    assign frame_tick = (cnt == CW'(FRAME_CYCLES - 1));
    assign cmd_ready  = (state == IDLE) && !estop;
    assign angle_out  = cur;

    always_comb begin
        busy = 1'b0;
        for (int n = 0; n < 4; n++)
            if (cur[n] != tgt[n]) busy = 1'b1;
    end

    // Targets never exceed 180, so stepping by STEP_DEG cannot wrap 8 bits.
    always_comb begin
        d  = $signed({1'b0, tgt[j]}) - $signed({1'b0, cur[j]});
        ad = (d < 0) ? -d : d;
        if (ad <= $signed(9'(STEP_DEG)))
            stepped = tgt[j];
        else if (d > 0)
            stepped = cur[j] + 8'(STEP_DEG);
        else
            stepped = cur[j] - 8'(STEP_DEG);
    end

    always_comb begin
        state_nx = state;
        j_nx     = j;
        cur_nx   = cur;
        tgt_nx   = tgt;
        chg_nx   = chg_frame;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (frame_tick) begin
                    state_nx = UPDATE;
                    j_nx     = 2'd0;
                    chg_nx   = 1'b0;
                end
                if (cmd_valid && cmd_ready)
                    tgt_nx[cmd_joint] = (cmd_angle > 8'd180) ? 8'd180 : cmd_angle;
            end
            UPDATE: begin
                if (!estop) begin
                    cur_nx[j] = stepped;
                    if (stepped != cur[j]) chg_nx = 1'b1;
                end
                j_nx = j + 2'd1;
                if (j == 2'd3) begin
                    state_nx = IDLE;
                    done_nx  = chg_nx && (cur_nx == tgt_nx);
                end
            end
            default: state_nx = IDLE;
        endcase
        // Emergency stop pins every target to where the joint is right now.
        if (estop) begin
            tgt_nx = cur;
            if (state == UPDATE && j == 2'd3) done_nx = chg_nx;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            state     <= IDLE;
            j         <= 2'd0;
            cur       <= {4{8'(HOME_DEG)}};
            tgt       <= {4{8'(HOME_DEG)}};
            chg_frame <= 1'b0;
            done      <= 1'b0;
        end else begin
            cnt       <= frame_tick ? '0 : cnt + CW'(1);
            state     <= state_nx;
            j         <= j_nx;
            cur       <= cur_nx;
            tgt       <= tgt_nx;
            chg_frame <= chg_nx;
            done      <= done_nx;
        end
    end
endmodule
